// File: rtl/detection_rle_if.sv
// Bundle between the CFAR detector side, the capture consumer and detection_rle.
// The slave view belongs to the encoder; the master view drives it.
interface detection_rle_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          decision;
  logic          in_rdy;
  logic          TRG;
  logic          HM;
  logic          BI;
  logic          out_ready;
  logic [31:0]   out_word;
  logic          out_valid;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output decision, in_rdy, TRG, HM, BI, out_ready,
    input  out_word, out_valid, fifo_level, overflow
  );

  modport slave (
    input  decision, in_rdy, TRG, HM, BI, out_ready,
    output out_word, out_valid, fifo_level, overflow
  );
endinterface

// File: rtl/detection_rle.sv
// Run-length encoder behind the CFAR detector: turns per-bin decisions and TRG/HM/BI
// markers into sweep header, run and overflow words queued in a first-word-fall-through FIFO.
module detection_rle #(
  parameter int AZ_BITS    = 12,
  parameter int MIN_RUN    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  detection_rle_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [14:0]   RANGE_MAX = 15'h7fff;
  localparam logic [14:0]   MIN_LEN   = 15'(MIN_RUN);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_state_t;

  logic               trg_q_r, hm_q_r, bi_q_r;
  logic               trg_edge_s, hm_edge_s, bi_edge_s;
  logic [AZ_BITS-1:0] az_r;
  logic [14:0]        range_r, range_cur_s, range_next_s;
  logic               sample_s;
  logic [17:0]        sweep_r;

  run_state_t         state_r, fsm_n_s, state_d_s;
  logic [14:0]        start_r, len_r, start_n_s, len_n_s;
  logic               open_s, close_s, sat_close_s, run_close_s, run_req_s;
  logic [14:0]        run_start_s, run_len_s;
  logic [31:0]        run_word_s;

  logic               hdr_pend_r, pend_n_s, hdr_req_s, pend_lost_s;
  logic [31:0]        hdr_word_r, pend_word_n_s, hdr_new_s, hdr_word_s;
  logic [15:0]        drop_r, drop_n_s;
  logic [16:0]        drop_sum_s;
  logic               ovf_r, ovf_push_s;
  logic               full_s, pop_s, push_req_s, push_drop_s, push_ok_s;
  logic [31:0]        push_word_s;

  logic [31:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]      count_r, count_n_s;
  logic               out_valid_r;

  assign trg_edge_s = bus.TRG & ~trg_q_r;
  assign hm_edge_s  = bus.HM  & ~hm_q_r;
  assign bi_edge_s  = bus.BI  & ~bi_q_r;

  // TRG restarts the bin count before the same-cycle sample is tagged
  always_comb begin
    range_cur_s  = trg_edge_s ? 15'd0 : range_r;
    sample_s     = bus.in_rdy & (range_cur_s != RANGE_MAX);
    range_next_s = sample_s ? (range_cur_s + 15'd1) : range_cur_s;
  end

  // Run tracking: a TRG edge closes an open run, then the sample is judged from IDLE
  always_comb begin
    fsm_n_s   = state_r;
    start_n_s = start_r;
    len_n_s   = len_r;
    close_s   = 1'b0;
    open_s    = (state_r == RUN);
    if (open_s && trg_edge_s) begin
      close_s = 1'b1;
      open_s  = 1'b0;
      fsm_n_s = IDLE;
    end else begin
      close_s = 1'b0;
    end
    if (sample_s) begin
      if (open_s) begin
        if (bus.decision) begin
          len_n_s = len_r + 15'd1;
        end else begin
          close_s = 1'b1;
          fsm_n_s = IDLE;
        end
      end else begin
        if (bus.decision) begin
          fsm_n_s   = RUN;
          start_n_s = range_cur_s;
          len_n_s   = 15'd1;
        end else begin
          fsm_n_s = IDLE;
        end
      end
    end else begin
      start_n_s = start_r;
    end
  end

  // A run still open when the range counter saturates is closed with its final length
  always_comb begin
    sat_close_s = (fsm_n_s == RUN) && (range_next_s == RANGE_MAX);
    state_d_s   = sat_close_s ? IDLE : fsm_n_s;
    run_close_s = close_s | sat_close_s;
    run_start_s = sat_close_s ? start_n_s : start_r;
    run_len_s   = sat_close_s ? len_n_s : len_r;
    run_req_s   = run_close_s && (run_len_s >= MIN_LEN);
    run_word_s  = {2'b01, run_start_s, run_len_s};
  end

  // One push per cycle: run, then header (parked if it loses), then overflow notice
  always_comb begin
    hdr_new_s     = {2'b10, 12'(az_r), sweep_r + 18'd1};
    hdr_req_s     = trg_edge_s | hdr_pend_r;
    hdr_word_s    = trg_edge_s ? hdr_new_s : hdr_word_r;
    pend_lost_s   = trg_edge_s & hdr_pend_r;
    full_s        = (count_r == DEPTH_L);
    pop_s         = out_valid_r & bus.out_ready;
    push_req_s    = 1'b0;
    push_word_s   = 32'd0;
    ovf_push_s    = 1'b0;
    pend_n_s      = hdr_pend_r;
    pend_word_n_s = hdr_word_r;
    if (run_req_s) begin
      push_req_s    = 1'b1;
      push_word_s   = run_word_s;
      pend_n_s      = hdr_req_s;
      pend_word_n_s = hdr_word_s;
    end else if (hdr_req_s) begin
      push_req_s  = 1'b1;
      push_word_s = hdr_word_s;
      pend_n_s    = 1'b0;
    end else if ((drop_r != 16'd0) && !full_s) begin
      push_req_s  = 1'b1;
      push_word_s = {2'b11, 14'd0, drop_r};
      ovf_push_s  = 1'b1;
    end else begin
      push_req_s = 1'b0;
    end
    push_drop_s = push_req_s & full_s & ~pop_s;
    push_ok_s   = push_req_s & ~push_drop_s;
    drop_sum_s  = {1'b0, drop_r} + {16'd0, push_drop_s} + {16'd0, pend_lost_s};
    drop_n_s    = ovf_push_s ? 16'd0 : (drop_sum_s[16] ? 16'hffff : drop_sum_s[15:0]);
    count_n_s   = count_r + LW'(push_ok_s) - LW'(pop_s);
  end

  // Marker edge history, azimuth, range and sweep counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trg_q_r <= 1'b0;
      hm_q_r  <= 1'b0;
      bi_q_r  <= 1'b0;
      az_r    <= {AZ_BITS{1'b0}};
      range_r <= 15'd0;
      sweep_r <= 18'd0;
    end else begin
      trg_q_r <= bus.TRG;
      hm_q_r  <= bus.HM;
      bi_q_r  <= bus.BI;
      range_r <= range_next_s;
      if (trg_edge_s) begin
        sweep_r <= sweep_r + 18'd1;
      end
      if (hm_edge_s) begin
        az_r <= {AZ_BITS{1'b0}};
      end else if (bi_edge_s) begin
        az_r <= az_r + AZ_BITS'(1);
      end
    end
  end

  // Run FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      start_r <= 15'd0;
      len_r   <= 15'd0;
    end else begin
      state_r <= state_d_s;
      start_r <= start_n_s;
      len_r   <= len_n_s;
    end
  end

  // Pending header, drop counter and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_pend_r <= 1'b0;
      hdr_word_r <= 32'd0;
      drop_r     <= 16'd0;
      ovf_r      <= 1'b0;
    end else begin
      hdr_pend_r <= pend_n_s;
      hdr_word_r <= pend_word_n_s;
      drop_r     <= drop_n_s;
      ovf_r      <= ovf_r | push_drop_s | pend_lost_s;
    end
  end

  // Output FIFO; the head entry is presented directly on out_word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {LW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_n_s;
      out_valid_r <= (count_n_s != {LW{1'b0}});
    end
  end

  assign bus.out_word   = mem_r[rd_ptr_r];
  assign bus.out_valid  = out_valid_r;
  assign bus.fifo_level = count_r;
  assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_detection_rle.sv
// Self-checking bench for detection_rle: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model of the encoder.
module tb_detection_rle;
  localparam int DEPTH = 4;
  localparam int MINR  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  detection_rle_if #(.FIFO_DEPTH(DEPTH)) bus ();

  detection_rle #(.AZ_BITS(12), .MIN_RUN(MINR), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model state
  bit          m_ptrg, m_phm, m_pbi, m_open, m_pend, m_ovf;
  int          m_az, m_range, m_sweep, m_start, m_len, m_drops;
  logic [31:0] m_pendw;
  logic [31:0] m_q[$];
  logic [31:0] seen[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptrg = 0; m_phm = 0; m_pbi = 0; m_open = 0; m_pend = 0; m_ovf = 0;
    m_az = 0; m_range = 0; m_sweep = 0; m_start = 0; m_len = 0; m_drops = 0;
    m_pendw = 32'd0;
    m_q.delete();
  endtask

  function automatic logic [31:0] mk_run(input int start, input int len);
    logic [14:0] s, l;
    s = 15'(start);
    l = 15'(len);
    return {2'b01, s, l};
  endfunction

  task automatic add_drop();
    m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
    m_ovf = 1;
  endtask

  task automatic try_push(input logic [31:0] w, input bit full, input bit pop);
    if (full && !pop) add_drop();
    else m_q.push_back(w);
  endtask

  task automatic model_step(input bit d, input bit rdy, input bit trg, input bit hm,
                            input bit bi, input bit ordy);
    bit te, he, be, pop, full, run_req, hdr_req;
    logic [31:0] run_w, hdr_w;
    logic [11:0] az12;
    logic [17:0] sw18;
    logic [15:0] dr16;
    te = trg && !m_ptrg; he = hm && !m_phm; be = bi && !m_pbi;
    m_ptrg = trg; m_phm = hm; m_pbi = bi;
    pop  = (m_q.size() > 0) && ordy;
    full = (m_q.size() == DEPTH);
    run_req = 0; run_w = 32'd0;
    hdr_req = m_pend; hdr_w = m_pendw;
    if (te) begin
      if (m_open && m_len >= MINR) begin run_req = 1; run_w = mk_run(m_start, m_len); end
      m_open = 0;
      m_range = 0;
      if (m_pend) add_drop();
      m_sweep = (m_sweep + 1) % 262144;
      az12 = 12'(m_az); sw18 = 18'(m_sweep);
      hdr_req = 1; hdr_w = {2'b10, az12, sw18};
    end
    if (rdy && m_range < 32767) begin
      if (m_open) begin
        if (d) m_len++;
        else begin
          if (m_len >= MINR) begin run_req = 1; run_w = mk_run(m_start, m_len); end
          m_open = 0;
        end
      end else if (d) begin
        m_open = 1; m_start = m_range; m_len = 1;
      end
      m_range++;
      if (m_open && m_range == 32767) begin
        if (m_len >= MINR) begin run_req = 1; run_w = mk_run(m_start, m_len); end
        m_open = 0;
      end
    end
    if (he) m_az = 0;
    else if (be) m_az = (m_az + 1) % 4096;
    if (pop) void'(m_q.pop_front());
    if (run_req) begin
      try_push(run_w, full, pop);
      m_pend = hdr_req;
      if (hdr_req) m_pendw = hdr_w;
    end else if (hdr_req) begin
      try_push(hdr_w, full, pop);
      m_pend = 0;
    end else if (m_drops > 0 && !full) begin
      dr16 = 16'(m_drops);
      m_q.push_back({2'b11, 14'd0, dr16});
      m_drops = 0;
    end
  endtask

  task automatic set_in(input bit d, input bit rdy, input bit trg, input bit hm,
                        input bit bi, input bit ordy);
    bus.decision = d; bus.in_rdy = rdy; bus.TRG = trg;
    bus.HM = hm; bus.BI = bi; bus.out_ready = ordy;
  endtask

  // one clock: model advances on the edge, outputs compared 1 ns later
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step(bus.decision, bus.in_rdy, bus.TRG, bus.HM, bus.BI, bus.out_ready);
    else model_reset();
    #1;
    check_val("valid", 32'(bus.out_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
    check_val("level", 32'(bus.fifo_level), 32'(m_q.size()));
    check_val("ovf", 32'(bus.overflow), 32'(m_ovf));
    if (m_q.size() > 0) check_val("word", bus.out_word, m_q[0]);
  endtask

  initial begin
    bit trg_lvl;
    logic [11:0] pat;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);

    // reset state
    repeat (3) cyc();
    check_val("rst_word", bus.out_word, 32'd0);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_level", 32'(bus.fifo_level), 32'd0);
    check_val("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    cyc();

    // first sweep: header then run over bins 3..5
    set_in(0, 1, 1, 0, 0, 1);
    cyc();
    check_val("hdr_first", bus.out_word, 32'h80000001);
    for (int b = 1; b < 10; b++) begin
      set_in(b >= 3 && b <= 5, 1, 1, 0, 0, 1);
      cyc();
      if (b == 6) check_val("run_first", bus.out_word, 32'h40018003);
    end
    set_in(0, 0, 1, 0, 0, 1);
    cyc();

    // azimuth: HM then 5 BI edges, then HM+BI together
    set_in(0, 0, 0, 0, 0, 1); cyc();
    set_in(0, 0, 0, 1, 0, 1); cyc();
    set_in(0, 0, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 1, 1); cyc();
      set_in(0, 0, 0, 0, 0, 1); cyc();
    end
    set_in(0, 0, 1, 0, 0, 1); cyc();
    check_val("hdr_az5", bus.out_word, 32'h80140002);
    set_in(0, 0, 0, 1, 1, 1); cyc();
    set_in(0, 0, 0, 0, 0, 1); cyc();
    set_in(0, 0, 1, 0, 0, 1); cyc();
    check_val("hdr_az0", bus.out_word, 32'h80000003);
    set_in(0, 0, 0, 0, 0, 1); cyc();

    // short runs below the minimum length vanish
    pat = 12'b110110111000;
    for (int b = 0; b < 12; b++) begin
      set_in(pat[11-b], 1, 1, 0, 0, 1);
      cyc();
      if (b == 2) check_val("short_run", 32'(bus.out_valid), 32'd0);
      if (b == 9) check_val("min_run", bus.out_word, 32'h40030003);
    end

    // TRG edge while a run is open
    set_in(0, 0, 0, 0, 0, 1); cyc();
    set_in(0, 1, 1, 0, 0, 1); cyc();
    for (int b = 1; b < 5; b++) begin set_in(1, 1, 1, 0, 0, 1); cyc(); end
    set_in(0, 0, 0, 0, 0, 1); cyc();
    set_in(1, 1, 1, 0, 0, 1); cyc();
    check_val("trg_close", bus.out_word, 32'h40008004);
    cyc();
    check_val("hdr_after", bus.out_word, 32'h80000006);
    cyc();
    set_in(0, 1, 1, 0, 0, 1); cyc();
    check_val("run_bin0", bus.out_word, 32'h40000003);

    // overflow: 7 headers into a 4-deep FIFO with consumer stalled
    set_in(0, 0, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 7; i++) begin
      set_in(0, 0, 1, 0, 0, 0); cyc();
      set_in(0, 0, 0, 0, 0, 0); cyc();
    end
    check_val("full_level", 32'(bus.fifo_level), 32'd4);
    check_val("full_ovf", 32'(bus.overflow), 32'd1);
    seen.delete();
    set_in(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid && bus.out_ready) seen.push_back(bus.out_word);
      cyc();
    end
    check_val("drain_cnt", 32'(seen.size()), 32'd5);
    if (seen.size() >= 5) check_val("ovf_word", seen[4], 32'hC0000003);

    // asynchronous reset with a run open and FIFO half full
    set_in(0, 0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0, 0); cyc();
    set_in(1, 1, 1, 0, 0, 0); cyc();
    cyc(); cyc();
    check_val("pre_rst_lvl", 32'(bus.fifo_level), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_level", 32'(bus.fifo_level), 32'd0);
    check_val("arst_ovf", 32'(bus.overflow), 32'd0);
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    set_in(0, 1, 0, 0, 0, 1);
    repeat (6) cyc();
    check_val("post_rst", 32'(bus.out_valid), 32'd0);

    // range saturation closes an open run
    set_in(0, 0, 0, 0, 0, 1); cyc();
    set_in(0, 1, 1, 0, 0, 1); cyc();
    for (int b = 1; b <= 32770; b++) begin
      set_in(b >= 32760 && b <= 32768, 1, 1, 0, 0, 1);
      cyc();
      if (b == 32766) check_val("sat_run", bus.out_word, 32'h7FFC0007);
    end

    // random traffic
    trg_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) trg_lvl = ~trg_lvl;
      set_in($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7, trg_lvl,
             $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
